// File: rtl/exec_shift_pipe.sv
// Pipelined barrel shifter: SHL/SHR/ASR/ROL/ROR/ZERO with {overflow, sign, zero, carry} flags.
// Latency STAGES cycles; every stage advances together only when the output slot is free or being consumed.
module exec_shift_pipe #(
  parameter int W_OPR  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [W_OPR-1:0] opr0_i,
  input  logic [W_OPR-1:0] opr1_i,
  input  logic [2:0]       select_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [W_OPR-1:0] result_o,
  output logic [3:0]       flags_o
);

  localparam int W_SH = $clog2(W_OPR);
  localparam int LPS  = (W_SH + STAGES - 1) / STAGES;

  localparam logic [2:0] M_SHL = 3'b000;
  localparam logic [2:0] M_SHR = 3'b001;
  localparam logic [2:0] M_ASR = 3'b010;
  localparam logic [2:0] M_ROL = 3'b100;
  localparam logic [2:0] M_ROR = 3'b101;

  typedef struct packed {
    logic             vld;
    logic [W_OPR-1:0] dat;
    logic             cy;
    logic [W_SH-1:0]  n;
    logic [2:0]       mode;
    logic             msb;
    logic [3:0]       flg;
  } stage_t;

  stage_t st_in;
  stage_t st_d [STAGES];
  stage_t st_q [STAGES];
  logic   advance;
  logic   unused_amt_bits;

  assign unused_amt_bits = ^opr1_i[W_OPR-1:W_SH];

  // Applies barrel levels [lo, hi) to one stage; the last stage also derives the flags.
  function automatic stage_t run_levels(input stage_t st, input int lo, input int hi,
                                        input logic last);
    stage_t           r;
    logic [W_OPR-1:0] mask;
    r    = st;
    mask = '0;
    for (int l = 0; l < W_SH; l++) begin
      if (l >= lo && l < hi && r.n[l]) begin
        case (r.mode)
          M_SHL: begin
            mask  = ~({W_OPR{1'b1}} >> (1 << l));
            r.cy  = r.cy | (|(r.dat & mask));
            r.dat = r.dat << (1 << l);
          end
          M_SHR: begin
            mask  = ~({W_OPR{1'b1}} << (1 << l));
            r.cy  = r.cy | (|(r.dat & mask));
            r.dat = r.dat >> (1 << l);
          end
          M_ASR: begin
            mask  = ~({W_OPR{1'b1}} << (1 << l));
            r.cy  = r.cy | (|(r.dat & mask));
            r.dat = $signed(r.dat) >>> (1 << l);
          end
          M_ROL:   r.dat = (r.dat << (1 << l)) | (r.dat >> (W_OPR - (1 << l)));
          M_ROR:   r.dat = (r.dat >> (1 << l)) | (r.dat << (W_OPR - (1 << l)));
          default: r.dat = r.dat;
        endcase
      end
    end
    if (last) begin
      r.flg = {r.msb ^ r.dat[W_OPR-1], r.dat[W_OPR-1], ~|r.dat, r.cy};
    end
    return r;
  endfunction

  assign advance    = ~out_valid_o | out_ready_i;
  assign in_ready_o = advance;

  always_comb begin
    st_in      = '0;
    st_in.vld  = in_valid_i;
    st_in.n    = opr1_i[W_SH-1:0];
    st_in.mode = select_i;
    st_in.msb  = opr0_i[W_OPR-1];
    // ZERO modes enter as a zero word, so no level can produce data or carry.
    st_in.dat  = (select_i inside {M_SHL, M_SHR, M_ASR, M_ROL, M_ROR}) ? opr0_i : '0;
    st_d[0]    = run_levels(st_in, 0, LPS, STAGES == 1);
    for (int s = 1; s < STAGES; s++) begin
      st_d[s] = run_levels(st_q[s-1], s * LPS, (s + 1) * LPS, s == STAGES - 1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int s = 0; s < STAGES; s++) st_q[s] <= '0;
    end else if (flush_i) begin
      for (int s = 0; s < STAGES; s++) st_q[s].vld <= 1'b0;
    end else if (advance) begin
      for (int s = 0; s < STAGES; s++) st_q[s] <= st_d[s];
    end
  end

  assign out_valid_o = st_q[STAGES-1].vld;
  assign result_o    = st_q[STAGES-1].dat;
  assign flags_o     = st_q[STAGES-1].flg;

endmodule

// File: tb/tb_exec_shift_pipe.sv
// Bench for exec_shift_pipe (W_OPR=32, STAGES=2): directed vectors plus random traffic vs a queue model.
module tb_exec_shift_pipe;

  localparam int W = 32;
  localparam int STG = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, flush, out_valid, out_ready;
  logic [W-1:0]  opr0, opr1, result;
  logic [2:0]    sel;
  logic [3:0]    flags;

  int n_chk = 0;
  int n_err = 0;
  logic [35:0] exp_q [$];
  logic        prev_hold;
  logic [35:0] prev_val;

  exec_shift_pipe #(.W_OPR(W), .STAGES(STG)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .opr0_i(opr0), .opr1_i(opr1), .select_i(sel), .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .result_o(result), .flags_o(flags)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: {overflow, sign, zero, carry, result} from plain double-width arithmetic.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] s);
    logic [31:0] nb;
    int          n;
    logic [63:0] w;
    logic [31:0] r;
    logic        c;
    nb = b % 32;
    n  = int'(nb);
    r  = '0;
    c  = 1'b0;
    case (s)
      3'd0: begin w = {32'b0, a} << n; r = w[31:0]; c = |w[63:32]; end
      3'd1: begin w = {a, 32'b0} >> n; r = w[63:32]; c = |w[31:0]; end
      3'd2: begin w = {a, 32'b0}; w = $signed(w) >>> n; r = w[63:32]; c = |w[31:0]; end
      3'd4: begin w = {a, a} << n; r = w[63:32]; end
      3'd5: begin w = {a, a} >> n; r = w[31:0]; end
      default: r = '0;
    endcase
    return {a[31] ^ r[31], r[31], r == 32'd0, c, r};
  endfunction

  // Scoreboard and protocol monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_hold <= 1'b0;
    end else begin
      check_eq("in_ready_rule", in_ready, !out_valid || out_ready);
      if (prev_hold) check_eq("hold_stable", {out_valid, flags, result}, {1'b1, prev_val});
      if (out_valid) begin
        if (exp_q.size() == 0) check_eq("spurious_out", out_valid, 0);
        else check_eq("result_flags", {flags, result}, exp_q[0]);
      end
      prev_hold <= out_valid && !out_ready && !flush;
      prev_val  <= {flags, result};
      if (flush) exp_q.delete();
      else begin
        if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        if (in_valid && in_ready) exp_q.push_back(model(opr0, opr1, sel));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] s, input logic [31:0] er, input logic [3:0] ef);
    out_ready = 1'b1;
    in_valid = 1'b1; opr0 = a; opr1 = b; sel = s;
    tick();
    in_valid = 1'b0;
    #3 check_eq({tag, "_early"}, out_valid, 0);
    tick();
    #3;
    check_eq({tag, "_lat"}, out_valid, 1);
    check_eq({tag, "_res"}, result, er);
    check_eq({tag, "_flg"}, flags, ef);
    tick();
  endtask

  task automatic stream(input int nops, input int stall_start, input int stall_len, input bit rnd);
    int          sent;
    int          cyc;
    logic        acc;
    logic [31:0] a, b;
    logic [2:0]  s;
    sent = 0;
    cyc  = 0;
    a = $urandom; b = $urandom; s = 3'($urandom_range(0, 7));
    while (sent < nops && cyc < 400) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      else out_ready = !(cyc >= stall_start && cyc < stall_start + stall_len);
      in_valid = 1'b1; opr0 = a; opr1 = b; sel = s;
      #3;
      if (!rnd && !out_ready) check_eq("stall_in_ready", in_ready, 0);
      acc = in_ready;
      tick();
      cyc++;
      if (acc) begin
        sent++;
        a = $urandom; b = $urandom; s = 3'($urandom_range(0, 7));
      end
    end
    check_eq("stream_sent", sent, nops);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    check_eq("stream_drained", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    opr0 = '0; opr1 = '0; sel = '0;
    #12;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_result", result, 0);
    check_eq("rst_flags", flags, 0);
    tick();
    rst_n = 1'b1;
    tick();

    run_one("shl1",   32'h8000_0001, 32'd1,  3'b000, 32'h0000_0002, 4'b1001);
    run_one("asr31",  32'h8000_0000, 32'd31, 3'b010, 32'hFFFF_FFFF, 4'b0100);
    run_one("shr36",  32'h0000_00F0, 32'd36, 3'b001, 32'h0000_000F, 4'b0000);
    run_one("ror1",   32'h0000_0001, 32'd1,  3'b101, 32'h8000_0000, 4'b1100);
    run_one("zero3",  32'h1234_5678, 32'd7,  3'b011, 32'h0000_0000, 4'b0010);
    run_one("zero6",  32'h8000_0000, 32'd3,  3'b110, 32'h0000_0000, 4'b1010);
    run_one("rol4",   32'h8000_0001, 32'd4,  3'b100, 32'h0000_0018, 4'b1000);
    run_one("shl0",   32'hFFFF_0000, 32'd64, 3'b000, 32'hFFFF_0000, 4'b0100);
    run_one("shr1",   32'h0000_0003, 32'd1,  3'b001, 32'h0000_0001, 4'b0001);

    stream(5, 3, 3, 1'b0);

    // Flush with two ops in flight and a third offered in the flush cycle.
    out_ready = 1'b1;
    in_valid = 1'b1; opr0 = 32'h0000_00FF; opr1 = 32'd2; sel = 3'b000;
    tick();
    opr0 = 32'h0000_0F00; sel = 3'b001;
    tick();
    out_ready = 1'b0; flush = 1'b1; opr0 = 32'h1111_1111; sel = 3'b100;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) begin
      #3 check_eq("flush_no_out", out_valid, 0);
      tick();
    end

    stream(40, 0, 0, 1'b1);

    // Asynchronous reset with a full, stalled pipeline.
    out_ready = 1'b0;
    in_valid = 1'b1; opr0 = 32'hDEAD_BEEF; opr1 = 32'd5; sel = 3'b101;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", out_valid, 0);
    check_eq("arst_in_ready", in_ready, 1);
    check_eq("arst_result", result, 0);
    check_eq("arst_flags", flags, 0);
    tick();
    in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b1;
    repeat (4) begin
      #3 check_eq("post_rst_no_out", out_valid, 0);
      tick();
    end

    stream(20, 0, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/exec_shift_pipe.md
EXEC_SHIFT_PIPE -- requirements
Module: exec_shift_pipe

Interface
REQ-001 SHALL take parameter W_OPR, default 32: operand/result width; power of two, 8..64.
REQ-002 SHALL take parameter STAGES, default 2: pipeline register stages, 1..log2(W_OPR).
REQ-003 SHALL define W_SH = log2(W_OPR) as a derived local parameter.
REQ-004 SHALL have port clk_i  in  1  clock, all state on rising edge.
REQ-005 SHALL have port rst_n_i  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid_i  in  1  operation offered.
REQ-007 SHALL have port in_ready_o  out  1  operation accepted when in_valid_i and in_ready_o are both high.
REQ-008 SHALL have port opr0_i  in  W_OPR  value to shift.
REQ-009 SHALL have port opr1_i  in  W_OPR  shift amount; only bits [W_SH-1:0] are used.
REQ-010 SHALL have port select_i  in  3  mode: 000 SHL, 001 SHR, 010 ASR, 011 ZERO, 100 ROL, 101 ROR, 110/111 ZERO.
REQ-011 SHALL have port flush_i  in  1  synchronous pipeline clear.
REQ-012 SHALL have port out_valid_o  out  1  result present.
REQ-013 SHALL have port out_ready_i  in  1  consumer accepts result.
REQ-014 SHALL have port result_o  out  W_OPR  shifted value.
REQ-015 SHALL have port flags_o  out  4  {overflow, sign, zero, carry}.

Function
REQ-016 SHALL use shift amount n = opr1_i[W_SH-1:0], i.e. the amount modulo W_OPR; upper opr1_i bits are ignored.
REQ-017 SHALL compute SHL = opr0 << n (zero fill), SHR = logical right (zero fill), ASR = arithmetic right (sign fill), ROL/ROR = rotate by n, ZERO = all zeros.
REQ-018 SHALL set carry = OR of all bits shifted out of the word (SHL: bits leaving the top; SHR/ASR: bits leaving the bottom); carry = 0 for ROL, ROR, ZERO and for any n = 0.
REQ-019 SHALL set zero = NOR of result, sign = result[W_OPR-1], overflow = opr0[W_OPR-1] XOR sign, in all modes.
REQ-020 SHALL implement the shift as log2(W_OPR) barrel levels spread over STAGES register stages, with each stage holding at most ceil(W_SH/STAGES) levels.
REQ-021 SHALL carry a valid bit and all intermediate data, mode and opr0 MSB in every stage.
REQ-022 SHALL have latency exactly STAGES cycles from acceptance to out_valid_o when never stalled, with throughput one operation per cycle.
REQ-023 SHALL define advance = ~out_valid_o | out_ready_i; in_ready_o = advance; all stages load together only when advance is high.
REQ-024 SHALL hold result_o, flags_o and out_valid_o stable while out_valid_o = 1 and out_ready_i = 0.
REQ-025 SHALL load a bubble (valid 0) into stage 1 when advance is high and in_valid_i is low.
REQ-026 SHALL preserve acceptance order and SHALL neither drop nor duplicate operations under any out_ready_i pattern.
REQ-027 SHALL, on flush_i high at a clock edge, clear every stage valid bit and accept no input that cycle; flush_i dominates in_valid_i and out_ready_i.
REQ-028 SHALL treat a result as consumed at the edge where out_valid_o and out_ready_i are both high, even in the same cycle a new operation is accepted.
REQ-029 SHALL drive result_o and flags_o from registers; they are don't-care when out_valid_o = 0.

Reset
REQ-030 SHALL, while rst_n_i is low, force all stage valid bits, result_o and flags_o to 0; out_valid_o = 0 and in_ready_o = 1.
REQ-031 SHALL discard in-flight operations on reset mid-operation, with no output after release until a new acceptance.

Verification (W_OPR=32, STAGES=2)
REQ-032 SHALL cover: SHL 0x8000_0001 by 1 -> result 0x0000_0002, flags 4'b1001, out_valid_o exactly 2 cycles after acceptance.
REQ-033 SHALL cover: ASR 0x8000_0000 by 31 -> 0xFFFF_FFFF, flags 4'b0100; SHR 0x0000_00F0 with opr1 36 -> 0x0000_000F, flags 4'b0000.
REQ-034 SHALL cover: ROR 0x0000_0001 by 1 -> 0x8000_0000, flags 4'b1100; select 011 on any input -> 0, flags 4'b0010 if opr0 MSB = 0.
REQ-035 SHALL cover: 5 back-to-back ops with out_ready_i low for 3 cycles mid-stream -> in_ready_o low during the stall, all 5 results delivered in order, outputs stable while stalled.
REQ-036 SHALL cover: flush_i pulsed with 2 ops in flight -> no out_valid_o for those ops; an op offered in the flush cycle is not accepted.
REQ-037 SHALL cover: rst_n_i low asynchronously with a full pipeline -> out_valid_o 0 immediately, in_ready_o 1, no stale output after release.
